// File: rtl/varsum_pool.sv
// Conserved-quantity pool: a hub cell and N-1 satellites, with handshaked transfers
// between the hub and one satellite, plus sticky hub-bound and wrap observers.
module varsum_pool #(
   parameter int unsigned N     = 5,
   parameter int unsigned W     = 8,
   parameter int unsigned INIT  = 1,
   parameter int unsigned BOUND = 5,
   localparam int unsigned SELW = $clog2(N),
   localparam int unsigned TW   = W + $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [SELW-1:0] req_sel,
   input  logic            req_dir,
   input  logic            req_mode,
   input  logic [W-1:0]    req_amt,
   output logic [N*W-1:0]  cells_o,
   output logic [W-1:0]    hub_o,
   output logic [TW-1:0]   total_o,
   output logic            done,
   output logic            err,
   output logic            bound_viol,
   output logic            wrap_flag
);

   // A BOUND at or above 2^W can never be exceeded by a W-bit hub.
   localparam bit BoundReachable = (W >= 32) || (64'(BOUND) < (64'(1) << W));

   typedef enum logic [1:0] {StIdle, StExec, StCommit} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    cell_q [N];
   logic [W-1:0]    cell_d [N];
   logic [SELW-1:0] sel_q;
   logic            dir_q, mode_q;
   logic [W-1:0]    amt_q;
   logic [W-1:0]    moved_q, moved_d;
   logic            illegal_q, illegal_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            wrap_q, wrap_d;
   logic            bound_q, bound_d;
   logic            accept;
   logic            sel_bad;
   logic [W-1:0]    sat_val, src_val, dst_val;
   logic [W:0]      dst_sum;

   assign req_ready  = (state_q == StIdle);
   assign accept     = req_valid & req_ready;
   assign sel_bad    = (sel_q == '0) || (32'(sel_q) >= N);
   assign done       = done_q;
   assign err        = err_q;
   assign bound_viol = bound_q;
   assign wrap_flag  = wrap_q;
   assign hub_o      = cell_q[0];

   // Mux the selected satellite without indexing past N-1 for non-power-of-two N.
   always_comb begin
      sat_val = '0;
      for (int unsigned k = 1; k < N; k++) begin
         if (32'(sel_q) == k) sat_val = cell_q[k];
      end
   end

   assign src_val = dir_q ? cell_q[0] : sat_val;
   assign dst_val = dir_q ? sat_val : cell_q[0];
   assign dst_sum = {1'b0, dst_val} + {1'b0, moved_q};

   always_comb begin
      state_d   = state_q;
      moved_d   = moved_q;
      illegal_d = illegal_q;
      cell_d    = cell_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wrap_d    = wrap_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StExec;
         end
         StExec: begin
            illegal_d = sel_bad;
            if (sel_bad) begin
               moved_d = '0;
            end else if (mode_q && (amt_q < src_val)) begin
               moved_d = amt_q;
            end else begin
               moved_d = src_val;
            end
            state_d = StCommit;
         end
         StCommit: begin
            done_d  = 1'b1;
            err_d   = illegal_q;
            state_d = StIdle;
            if (!illegal_q) begin
               for (int unsigned k = 1; k < N; k++) begin
                  if (32'(sel_q) == k) begin
                     cell_d[k] = dir_q ? dst_sum[W-1:0] : cell_q[k] - moved_q;
                  end
               end
               cell_d[0] = dir_q ? cell_q[0] - moved_q : dst_sum[W-1:0];
               if (dst_sum[W]) wrap_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      bound_d = bound_q | (BoundReachable && (cell_d[0] > W'(BOUND)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         for (int unsigned k = 0; k < N; k++) cell_q[k] <= W'(INIT);
         sel_q     <= '0;
         dir_q     <= 1'b0;
         mode_q    <= 1'b0;
         amt_q     <= '0;
         moved_q   <= '0;
         illegal_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         wrap_q    <= 1'b0;
         bound_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (accept) begin
            sel_q  <= req_sel;
            dir_q  <= req_dir;
            mode_q <= req_mode;
            amt_q  <= req_amt;
         end
         cell_q    <= cell_d;
         moved_q   <= moved_d;
         illegal_q <= illegal_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wrap_q    <= wrap_d;
         bound_q   <= bound_d;
      end
   end

   always_comb begin
      cells_o = '0;
      total_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cells_o[k*W +: W] = cell_q[k];
         total_o           = total_o + TW'(cell_q[k]);
      end
   end

endmodule

// File: tb/tb_varsum_pool.sv
// Scoreboard bench for varsum_pool: a default instance (A) and a narrow W=3, INIT=5 instance (B).
module tb_varsum_pool;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_a = 1'b0, valid_b = 1'b0;
   logic [2:0]  sel = '0;
   logic        dir = 1'b0, mode = 1'b0;
   logic [7:0]  amt = '0;

   logic        ready_a, done_a, err_a, bv_a, wrap_a;
   logic [39:0] cells_a;
   logic [7:0]  hub_a;
   logic [10:0] total_a;

   logic        ready_b, done_b, err_b, bv_b, wrap_b;
   logic [14:0] cells_b;
   logic [2:0]  hub_b;
   logic [5:0]  total_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int ci;
      int hub;
      int sat;
      int tot;
      bit err;
      bit wrap;
      bit bv;
      int acc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   varsum_pool #(.N(5), .W(8), .INIT(1), .BOUND(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
      .req_sel(sel), .req_dir(dir), .req_mode(mode), .req_amt(amt),
      .cells_o(cells_a), .hub_o(hub_a), .total_o(total_a), .done(done_a),
      .err(err_a), .bound_viol(bv_a), .wrap_flag(wrap_a)
   );

   varsum_pool #(.N(5), .W(3), .INIT(5), .BOUND(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
      .req_sel(sel), .req_dir(dir), .req_mode(mode), .req_amt(amt[2:0]),
      .cells_o(cells_b), .hub_o(hub_b), .total_o(total_b), .done(done_b),
      .err(err_b), .bound_viol(bv_b), .wrap_flag(wrap_b)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop an expectation on every done pulse.
   always @(negedge clk) begin
      if (done_a) begin
         if (qa.size() == 0) begin
            chk("a_spurious_done", 1, 0);
         end else begin
            ea = qa.pop_front();
            chk("a_hub", hub_a, ea.hub);
            chk("a_cell", cells_a[ea.ci*8 +: 8], ea.sat);
            chk("a_total", total_a, ea.tot);
            chk("a_err", err_a, ea.err);
            chk("a_wrap", wrap_a, ea.wrap);
            chk("a_bound", bv_a, ea.bv);
            chk("a_latency", cyc - ea.acc, 2);
         end
      end else if (err_a) begin
         chk("a_err_without_done", 1, 0);
      end
   end

   always @(negedge clk) begin
      if (done_b) begin
         if (qb.size() == 0) begin
            chk("b_spurious_done", 1, 0);
         end else begin
            eb = qb.pop_front();
            chk("b_hub", hub_b, eb.hub);
            chk("b_cell", cells_b[eb.ci*3 +: 3], eb.sat);
            chk("b_total", total_b, eb.tot);
            chk("b_err", err_b, eb.err);
            chk("b_wrap", wrap_b, eb.wrap);
            chk("b_bound", bv_b, eb.bv);
            chk("b_latency", cyc - eb.acc, 2);
         end
      end else if (err_b) begin
         chk("b_err_without_done", 1, 0);
      end
   end

   // Issue one request to instance b (0 = A, 1 = B) and queue its hand-computed result.
   // ci is the cell checked at done; hold keeps req_valid high through the busy cycles.
   task automatic issue(input bit b, input int s, input bit d, input bit m, input int a,
                        input bit hold, input int ci, input int e_hub, input int e_sat,
                        input int e_tot, input bit e_err, input bit e_wrap, input bit e_bv);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      while (!(b ? ready_b : ready_a) && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) chk("ready_timeout", 0, 1);
      sel  = s[2:0];
      dir  = d;
      mode = m;
      amt  = a[7:0];
      if (b) valid_b = 1'b1;
      else   valid_a = 1'b1;
      @(posedge clk);
      #1;
      e.ci = ci; e.hub = e_hub; e.sat = e_sat; e.tot = e_tot;
      e.err = e_err; e.wrap = e_wrap; e.bv = e_bv; e.acc = cyc;
      if (b) qb.push_back(e);
      else   qa.push_back(e);
      if (!hold) begin
         valid_a = 1'b0;
         valid_b = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ready_busy", b ? ready_b : ready_a, (i == 2) ? 1 : 0);
      end
      valid_a = 1'b0;
      valid_b = 1'b0;
      #1;
      chk("done_seen", b ? qb.size() : qa.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cells_a", cells_a, 40'h0101010101);
      chk("rst_total_a", total_a, 5);
      chk("rst_ready_a", ready_a, 1);
      chk("rst_done_a", done_a, 0);
      chk("rst_bound_a", bv_a, 0);
      chk("rst_wrap_a", wrap_a, 0);
      chk("rst_total_b", total_b, 25);

      // B: wrap on first pull, bound on second, bound stays after hub is emptied.
      issue(1, 1, 0, 0, 0, 0, 1, 2, 0, 17, 0, 1, 0);
      issue(1, 2, 0, 0, 0, 0, 2, 7, 0, 17, 0, 1, 1);
      issue(1, 1, 1, 0, 0, 0, 1, 0, 7, 17, 0, 1, 1);

      // A: gather everything into the hub; hub = 5 sits exactly at BOUND.
      issue(0, 1, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0, 0);
      issue(0, 2, 0, 0, 0, 0, 2, 3, 0, 5, 0, 0, 0);
      issue(0, 3, 0, 0, 0, 0, 3, 4, 0, 5, 0, 0, 0);
      issue(0, 4, 0, 0, 0, 0, 4, 5, 0, 5, 0, 0, 0);
      issue(0, 2, 1, 0, 0, 0, 2, 0, 5, 5, 0, 0, 0);
      issue(0, 2, 0, 1, 3, 0, 2, 3, 2, 5, 0, 0, 0);
      issue(0, 2, 0, 1, 7, 0, 2, 5, 0, 5, 0, 0, 0);
      issue(0, 3, 1, 1, 0, 0, 3, 5, 0, 5, 0, 0, 0);
      issue(0, 1, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0);
      issue(0, 0, 1, 0, 0, 1, 0, 5, 5, 5, 1, 0, 0);
      issue(0, 7, 0, 0, 0, 1, 4, 5, 0, 5, 1, 0, 0);
      issue(0, 4, 1, 1, 2, 0, 4, 3, 2, 5, 0, 0, 0);

      // Reset while A is in EXEC: cells snap back, no done pulse.
      @(negedge clk);
      sel = 3'd1; dir = 1'b1; mode = 1'b0; amt = '0;
      valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      chk("busy_before_rst", ready_a, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_cells_a", cells_a, 40'h0101010101);
      chk("rst_mid_ready_a", ready_a, 1);
      chk("rst_mid_done_a", done_a, 0);
      chk("rst_mid_total_b", total_b, 25);
      chk("rst_mid_bound_b", bv_b, 0);
      chk("rst_mid_wrap_b", wrap_b, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(0, 1, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/varsum_pool.md
Name: varsum_pool

Overview:
- Parametrised conserved-quantity pool: one hub cell (cell 0) and N-1 satellite cells, each W bits wide.
- Handshaked requests move value between the hub and one selected satellite.
- Two transfer modes: full drain and partial amount.
- Built-in observers for a hub upper bound and for arithmetic wrap. These are targets for BMC/k-induction flows, and the block also serves as a scalable formal benchmark.

Parameters:
- N, 5, total number of cells including the hub (N >= 2).
- W, 8, width of each cell in bits.
- INIT, 1, reset value of every cell (W bits).
- BOUND, 5, hub value above which bound_viol is raised.
- SELW, $clog2(N) (local, not overridable), width of req_sel.
- TW, W+$clog2(N) (local, not overridable), width of total_o.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_sel  in  SELW  satellite index; legal range 1..N-1.
- req_dir  in  1  0 = pull (satellite to hub), 1 = push (hub to satellite).
- req_mode  in  1  0 = full (move entire source value), 1 = partial (move req_amt).
- req_amt  in  W  requested amount; used only in partial mode.
- cells_o  out  N*W  cell k occupies bits [k*W +: W].
- hub_o  out  W  cell 0; same as cells_o[W-1:0].
- total_o  out  TW  unsigned sum of all cells; combinational from cell registers.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse, coincident with done, for an illegal req_sel.
- bound_viol  out  1  sticky; set when hub_o > BOUND.
- wrap_flag  out  1  sticky; set when a destination add carries out of W bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - every cell = INIT; FSM = IDLE;
  - req_ready = 1; done = err = bound_viol = wrap_flag = 0;
  - any in-flight request is discarded with no partial update.
- FSM states: IDLE, EXEC, COMMIT.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch sel/dir/mode/amt, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - req_ready = 0.
  - src = satellite if dir = 0, hub if dir = 1; dst is the other cell.
  - Register moved:
    - full mode: moved = src;
    - partial mode: moved = min(req_amt, src), unsigned compare, so src never underflows.
  - If sel == 0 or sel >= N: mark illegal and set moved = 0.
  - Go to COMMIT.
- COMMIT:
  - req_ready = 0.
  - Write src <= src - moved and dst <= (dst + moved) mod 2^W.
  - Both cells update on the same edge; no other cell changes.
  - done = 1 for this cycle; err = 1 too if illegal.
  - An illegal request changes no cell.
  - Next state: IDLE.
- Timing: request accepted at edge t; cell update and done visible after edge t+2; next acceptance possible at edge t+3. Throughput is one request per 3 cycles.
- Requests while req_ready = 0 are ignored. req_valid has no hold requirement after acceptance.
- wrap_flag: set on the COMMIT edge when dst + moved >= 2^W; held until reset.
- bound_viol: set on any edge where the updated hub value > BOUND; held until reset.
- Conservation: without wrap, total_o is invariant across every request. With wrap, total_o drops by exactly 2^W per wrap event.
- Moves of zero (src = 0, or req_amt = 0) are legal: done pulses, no cell changes.
- Reset asserted in EXEC or COMMIT: immediate return to reset values; no done pulse.

Test Plan:
- Defaults; pull full on sel 1, 2, 3, 4 in sequence:
  - hub_o = 2, 3, 4, 5; satellites go to 0; total_o = 5 throughout;
  - bound_viol = 0; exactly 4 done pulses, each 2 cycles after acceptance.
- Defaults, then push full on sel 2:
  - cell2 = 2, hub = 0;
  - partial pull sel 2 with amt = 7 moves min(7, 2) = 2: cell2 = 0, hub = 2.
- INIT = 2, BOUND = 5; pull full on sels 1, 2, 3:
  - hub = 4, 6, 8;
  - bound_viol rises on the edge hub becomes 6 and stays 1 after a later push empties the hub.
- W = 3, INIT = 5; pull full on sel 1:
  - hub = 10 mod 8 = 2; cell1 = 0; wrap_flag = 1;
  - total_o drops from 25 to 17.
- Defaults; req_sel = 0, then req_sel = 7:
  - each produces done with err, all cells unchanged, req_ready low for exactly 2 cycles;
  - req_valid held high during busy does not cause extra acceptances.
- Accept a push, then assert rst_n = 0 during EXEC:
  - all cells = 1 immediately; no done pulse;
  - req_ready = 1 after release; the next request behaves normally.
